// File: rtl/popcount_frame_accumulator_pkg.sv
// Shared definitions for the popcount frame accumulator.
//   state_t    : frame FSM states (IDLE / ACCUM / HOLD)
//   POPCNT_MAX : largest legal per-byte ones-count from the decoder
package popcount_frame_accumulator_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] POPCNT_MAX = 4'd8;

endpackage

// File: rtl/popcount_frame_accumulator_counter.sv
// frame_word_counter: counts accepted words within one frame.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (new frame)
//   en       : count one accepted word
//   tc       : high while the counter sits on the last word of the frame
module frame_word_counter #(
    parameter int WORDS_PER_FRAME = 32,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == CNT_W'(WORDS_PER_FRAME - 1));

    // Wrap to zero on the last word so the counter never runs past the
    // frame length even when 2**CNT_W > WORDS_PER_FRAME.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/popcount_frame_accumulator.sv
// popcount_frame_accumulator: sums WORDS_PER_FRAME per-byte ones-counts
// and presents the frame total with a valid/ready handshake.
//   clk, rst   : clock, async active-high reset
//   start      : begin a frame (IDLE, or HOLD together with out_ready)
//   in_valid / in_ready / popcnt_in : word input handshake (0..8 legal)
//   out_valid / out_ready / sum_out : frame total output handshake
//   busy       : high while accumulating
//   err        : sticky flag, an input word exceeded 8 in this frame
module popcount_frame_accumulator
    import popcount_frame_accumulator_pkg::*;
#(
    parameter int WORDS_PER_FRAME = 32,
    parameter int SUM_W           = 9,
    parameter int CNT_W           = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       popcnt_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] sum_out,
    output logic             busy,
    output logic             err
);

    state_t           state, state_nxt;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_add;
    logic [3:0]       value;
    logic             illegal;
    logic             accept;
    logic             last;
    logic             new_frame;
    logic             tc;

    assign illegal   = (popcnt_in > POPCNT_MAX);
    assign value     = illegal ? POPCNT_MAX : popcnt_in;
    assign acc_add   = acc + SUM_W'(value);
    assign accept    = (state == S_ACCUM) && in_valid;
    assign last      = accept && tc;
    // A frame opens from IDLE on start, or straight out of HOLD when the
    // result is consumed in the same cycle start is raised.
    assign new_frame = ((state == S_IDLE) && start) ||
                       ((state == S_HOLD) && out_ready && start);

    frame_word_counter #(
        .WORDS_PER_FRAME(WORDS_PER_FRAME),
        .CNT_W          (CNT_W)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(new_frame),
        .en (accept),
        .tc (tc)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)     state_nxt = S_ACCUM;
            S_ACCUM: if (last)      state_nxt = S_HOLD;
            S_HOLD:  if (out_ready) state_nxt = start ? S_ACCUM : S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_HOLD:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            sum_out <= '0;
            err     <= 1'b0;
        end else if (new_frame) begin
            acc <= '0;
            err <= 1'b0;
        end else if (accept) begin
            acc <= acc_add;
            if (illegal)
                err <= 1'b1;
            if (tc)
                sum_out <= acc_add;
        end
    end

endmodule
